// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a Gray-coded shadow register, plus an independent
// one-cycle binary-to-Gray stream converter. Every output comes straight from a flop.
module bin_to_gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] G,
  output logic             wrap,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_gray
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_gray_q, out_gray_d;
  logic [WIDTH-1:0] stream_gray;

  // Counter next state: load beats en; wrap flags only enabled steps across the end.
  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (load) begin
      b_d = D;
    end else if (en) begin
      if (up) begin
        b_d    = b_q + WIDTH'(1);
        wrap_d = (b_q == {WIDTH{1'b1}});
      end else begin
        b_d    = b_q - WIDTH'(1);
        wrap_d = (b_q == {WIDTH{1'b0}});
      end
    end
  end

  // Gray is encoded from the next binary value so G and B register in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_enc
      assign g_d[gi]         = b_d[gi+1] ^ b_d[gi];
      assign stream_gray[gi] = in_bin[gi+1] ^ in_bin[gi];
    end
  endgenerate
  assign g_d[WIDTH-1]         = b_d[WIDTH-1];
  assign stream_gray[WIDTH-1] = in_bin[WIDTH-1];

  always_comb begin
    out_vld_d  = in_vld;
    out_gray_d = out_gray_q;
    if (in_vld) begin
      out_gray_d = stream_gray;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q        <= '0;
      g_q        <= '0;
      wrap_q     <= 1'b0;
      out_vld_q  <= 1'b0;
      out_gray_q <= '0;
    end else begin
      b_q        <= b_d;
      g_q        <= g_d;
      wrap_q     <= wrap_d;
      out_vld_q  <= out_vld_d;
      out_gray_q <= out_gray_d;
    end
  end

  assign B        = b_q;
  assign G        = g_q;
  assign wrap     = wrap_q;
  assign out_vld  = out_vld_q;
  assign out_gray = out_gray_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Self-checking bench for bin_to_gray_counter: vector table, hand-written corner
// sequences and a randomised run, all compared through an expected-value queue.
module tb_bin_to_gray_counter;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] D;
  logic [W-1:0] B;
  logic [W-1:0] G;
  logic         wrap;
  logic         in_vld;
  logic [W-1:0] in_bin;
  logic         out_vld;
  logic [W-1:0] out_gray;

  bin_to_gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .D(D),
    .B(B), .G(G), .wrap(wrap),
    .in_vld(in_vld), .in_bin(in_bin), .out_vld(out_vld), .out_gray(out_gray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         wr;
    logic         ov;
    logic [W-1:0] og;
  } exp_t;

  typedef struct {
    logic         ld;
    logic         en;
    logic         up;
    logic [W-1:0] d;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         wr;
  } vec_t;

  exp_t   sb_q[$];
  vec_t   tbl[$];
  int     tests;
  int     failed;

  logic [W-1:0] m_b;
  logic [W-1:0] m_g;
  logic         m_wr;
  logic         m_ov;
  logic [W-1:0] m_og;

  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (i == W - 1) ? x[i] : (x[i] ^ x[i+1]);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    r[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic vec_t mk(input logic ld, input logic e, input logic u, input logic [W-1:0] d,
                              input logic [W-1:0] b, input logic [W-1:0] g, input logic wr);
    vec_t v;
    v.ld = ld; v.en = e; v.up = u; v.d = d; v.b = b; v.g = g; v.wr = wr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_b = '0; m_g = '0; m_wr = 1'b0; m_ov = 1'b0; m_og = '0;
    sb_q.delete();
  endtask

  // One clock: drive inputs, push model expectation, compare after the edge.
  task automatic drive_cycle(input logic ld, input logic e, input logic u, input logic [W-1:0] d,
                             input logic iv, input logic [W-1:0] ib);
    exp_t         x;
    logic [W-1:0] prev_g;
    load = ld; en = e; up = u; D = d; in_vld = iv; in_bin = ib;
    prev_g = m_g;
    m_wr = !ld && e && (u ? (m_b == {W{1'b1}}) : (m_b == {W{1'b0}}));
    if (ld)     m_b = d;
    else if (e) m_b = u ? m_b + W'(1) : m_b - W'(1);
    m_g = ref_gray(m_b);
    m_ov = iv;
    if (iv) m_og = ref_gray(ib);
    x.b = m_b; x.g = m_g; x.wr = m_wr; x.ov = m_ov; x.og = m_og;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("B", 32'(B), 32'(x.b));
    check("G", 32'(G), 32'(x.g));
    check("wrap", 32'(wrap), 32'(x.wr));
    check("out_vld", 32'(out_vld), 32'(x.ov));
    check("out_gray", 32'(out_gray), 32'(x.og));
    check("g2b(G)", 32'(ref_g2b(G)), 32'(x.b));
    if (!ld) check("hamming", $countones(G ^ prev_g), e ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] gseq [16];
    vec_t         v;
    tests = 0; failed = 0;
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    for (int k = 0; k < 16; k++) tbl.push_back(mk(1'b0, 1'b1, 1'b1, '0, W'(k + 1), gseq[k], k == 15));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 4'b1010, 4'b1010, 4'b1111, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'b1101, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0110, 4'b1111, 4'b1000, 1'b0));

    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; D = '0; in_vld = 1'b0; in_bin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check("rst B", 32'(B), 0);
    check("rst G", 32'(G), 0);
    check("rst wrap", 32'(wrap), 0);
    check("rst out_vld", 32'(out_vld), 0);
    check("rst out_gray", 32'(out_gray), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      drive_cycle(v.ld, v.en, v.up, v.d, 1'b0, '0);
      $display("[TB] vec %0d ld=%0b en=%0b up=%0b d=%b -> B=%b G=%b wrap=%0b", i, v.ld, v.en, v.up, v.d, B, G, wrap);
      check("tbl B", 32'(B), 32'(v.b));
      check("tbl G", 32'(G), 32'(v.g));
      check("tbl wrap", 32'(wrap), 32'(v.wr));
    end

    // Asynchronous reset mid-count, with the stream output valid.
    drive_cycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, '0);
    for (int k = 0; k < 5; k++) drive_cycle(1'b0, 1'b1, 1'b1, '0, 1'b1, W'($urandom));
    check("pre-rst B", 32'(B), 32'(4'b0101));
    check("pre-rst G", 32'(G), 32'(4'b0111));
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset: B=%b G=%b wrap=%0b out_vld=%0b", B, G, wrap, out_vld);
    check("async B", 32'(B), 0);
    check("async G", 32'(G), 0);
    check("async wrap", 32'(wrap), 0);
    check("async out_vld", 32'(out_vld), 0);
    check("async out_gray", 32'(out_gray), 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    drive_cycle(1'b0, 1'b1, 1'b1, '0, 1'b0, '0);
    check("post-rst B", 32'(B), 1);
    check("post-rst G", 32'(G), 1);

    // Stream converter alongside counter stepping.
    drive_cycle(1'b0, 1'b1, 1'b1, '0, 1'b1, 4'b0110);
    $display("[TB] stream in=0110 -> out_vld=%0b out_gray=%b", out_vld, out_gray);
    check("stream0 vld", 32'(out_vld), 1);
    check("stream0 gray", 32'(out_gray), 32'(4'b0101));
    drive_cycle(1'b0, 1'b1, 1'b1, '0, 1'b1, 4'b1111);
    $display("[TB] stream in=1111 -> out_vld=%0b out_gray=%b", out_vld, out_gray);
    check("stream1 gray", 32'(out_gray), 32'(4'b1000));
    drive_cycle(1'b0, 1'b1, 1'b1, '0, 1'b0, 4'b0011);
    $display("[TB] stream idle -> out_vld=%0b out_gray=%b", out_vld, out_gray);
    check("stream2 vld", 32'(out_vld), 0);
    check("stream2 hold", 32'(out_gray), 32'(4'b1000));
    check("stream B", 32'(B), 4);

    for (int k = 0; k < 1000; k++) begin
      drive_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
                  W'($urandom), 1'($urandom), W'($urandom));
      if (k % 100 == 0) $display("[TB] random cycle %0d B=%b G=%b wrap=%0b", k, B, G, wrap);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/bin_to_gray_counter.md
Name: bin_to_gray_counter

Overview:
- Binary-to-Gray encoder side of the Gray/binary code pair: an up/down binary counter with a registered Gray-coded output.
- Also provides a 1-cycle registered binary-to-Gray stream converter.
- Used as a Gray pointer source, e.g. for FIFO/CDC pointers. Its Gray output feeds the existing Gray-to-binary decoder on the far side.
- Single clock domain.

Parameters:
- WIDTH, 4, bit width of counter, load value, stream data and all Gray outputs (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of D; priority over en.
- D  input  WIDTH  binary load value.
- B  output  WIDTH  registered binary count.
- G  output  WIDTH  registered Gray code of B, same cycle alignment as B.
- wrap  output  1  registered one-cycle pulse on counter wrap.
- in_vld  input  1  stream input valid.
- in_bin  input  WIDTH  stream binary input.
- out_vld  output  1  stream output valid.
- out_gray  output  WIDTH  stream Gray output.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-count):
  - B=0, G=0, wrap=0, out_vld=0, out_gray=0.
  - Counting resumes on the first rising edge after rst_n deasserts.
- Encoding rule: Gray(x) = x XOR (x >> 1). MSB passes through; bit i = x[i+1] XOR x[i].
- G is computed from the next binary value and registered alongside it, so G == Gray(B) holds every cycle. No extra latency between B and G.
- Counter next-state, evaluated per rising edge, priority order:
  - load=1: B <= D, G <= Gray(D), wrap <= 0. en and up are ignored.
  - en=1, up=1: B <= (B+1) mod 2^WIDTH.
  - en=1, up=0: B <= (B-1) mod 2^WIDTH.
  - otherwise: hold B and G; wrap <= 0.
- Arithmetic is unsigned, WIDTH bits; carry and borrow are discarded.
- wrap:
  - High for exactly one cycle after an en step takes B from 2^WIDTH-1 to 0 (up), or from 0 to 2^WIDTH-1 (down).
  - Never asserted by load, even if D causes a numeric discontinuity.
- Single-step property: every en step, including wrap steps, changes exactly one bit of G (Hamming distance 1). A hold changes zero bits.
- Direction reversal: changing up between consecutive enabled cycles is legal. The counter steps back immediately with no dead cycle.
- Stream converter, independent of the counter:
  - No backpressure.
  - On each edge: out_vld <= in_vld. When in_vld=1, out_gray <= Gray(in_bin). When in_vld=0, out_gray holds its last value.
  - Latency is exactly 1 cycle. Back-to-back inputs give back-to-back outputs.
- Simultaneous events: load and en both high means load wins. Stream and counter activity in the same cycle do not interact.
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.

Test Plan:
- Reset, then en=1, up=1 for 16 cycles (WIDTH=4) -> G sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap=1 only in the cycle after B returns to 0. Every step has Hamming distance 1.
- load=1, D=1010 with en=1, up=1 in the same cycle -> next cycle B=1010, G=1111, wrap=0. Then a down step -> B=1001, G=1101.
- From B=0: en=1, up=0 -> B=1111, G=1000, wrap=1 for one cycle. Hold en=0 for 3 cycles -> B, G unchanged and wrap=0.
- Count up to B=0101 (G=0111), then pulse rst_n low between clock edges -> B, G, wrap, out_vld go to 0 without waiting for a clock edge. First enabled edge after release gives B=0001, G=0001.
- Stream: in_vld=1 with in_bin=0110, then 1111, then in_vld=0 -> out_vld=1, out_gray=0101 next cycle; then out_gray=1000; then out_vld=0 with out_gray holding 1000. Concurrent counter stepping is unaffected.
- Randomised 1000-cycle run against the reference model Gray(B) -> G == Gray(B) every cycle, Hamming distance ≤1 on every non-load cycle, and a Gray-to-binary decode of G equals B.
